// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the fetch PC, tagging in-order memory responses and buffering them for decode
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-high reset
//   Branch, BrPC             execute-stage redirect strobe and target (low two bits ignored)
//   stall                    decode cannot accept the head instruction this cycle
//   imem_req/imem_addr       request valid and address, handshaked by imem_rdy
//   imem_rdata_vld/rdata     in-order instruction responses
//   inst_vld/inst_out/PC_out FIFO head valid, instruction word and its PC
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Branch,
  input  logic [31:0] BrPC,
  input  logic        stall,
  input  logic        imem_rdy,
  input  logic        imem_rdata_vld,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        inst_vld,
  output logic [31:0] inst_out,
  output logic [31:0] PC_out
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [31:0]   r_pc;
  logic [31:0]   r_pend [DEPTH];
  logic [31:0]   r_inst [DEPTH];
  logic [31:0]   r_ipc  [DEPTH];
  logic [IW-1:0] r_pend_wr, r_pend_rd, r_wr, r_rd;
  logic [CW-1:0] r_count, r_out, r_drop;
  logic [CW:0]   w_used;
  logic [CW-1:0] w_out_rsp;
  logic          w_acc, w_keep, w_pop;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  // Buffered entries plus in-flight requests never exceed DEPTH, so every response has a FIFO slot.
  assign w_used    = {1'b0, r_count} + {1'b0, r_out};
  assign imem_req  = !rst && !Branch && (w_used < (CW+1)'(DEPTH));
  assign imem_addr = r_pc;
  assign inst_vld  = r_count != '0;
  assign inst_out  = inst_vld ? r_inst[r_rd] : '0;
  assign PC_out    = inst_vld ? r_ipc[r_rd] : '0;
  assign w_acc     = imem_req && imem_rdy;
  assign w_keep    = imem_rdata_vld && !Branch && r_drop == '0;
  assign w_pop     = inst_vld && !stall && !Branch;
  assign w_out_rsp = r_out - CW'(imem_rdata_vld);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_pend_wr <= '0;
      r_pend_rd <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_out     <= '0;
      r_drop    <= '0;
    end else begin
      // Every response consumes its tag, whether it is kept or dropped.
      if (imem_rdata_vld) r_pend_rd <= inc(r_pend_rd);
      if (Branch) begin
        r_pc    <= {BrPC[31:2], 2'b00};
        r_wr    <= '0;
        r_rd    <= '0;
        r_count <= '0;
        r_out   <= w_out_rsp;
        r_drop  <= w_out_rsp;
      end else begin
        if (w_acc) begin
          r_pend_wr <= inc(r_pend_wr);
          r_pc      <= r_pc + 32'd4;
        end
        if (w_keep) r_wr <= inc(r_wr);
        if (w_pop) r_rd <= inc(r_rd);
        if (imem_rdata_vld && r_drop != '0) r_drop <= r_drop - 1'b1;
        r_out   <= w_out_rsp + CW'(w_acc);
        r_count <= r_count + CW'(w_keep) - CW'(w_pop);
      end
    end
  end
  // Payload storage needs no reset: outputs are masked by inst_vld and tags are only read once written.
  always_ff @(posedge clk) begin
    if (w_acc) r_pend[r_pend_wr] <= r_pc;
    if (w_keep) begin
      r_inst[r_wr] <= imem_rdata;
      r_ipc[r_wr]  <= r_pend[r_pend_rd];
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(imem_rdata_vld && r_out == '0));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle-by-cycle check of fetch_unit with DEPTH=2
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Branch = 1'b0;
  logic        stall = 1'b0;
  logic        imem_rdy = 1'b0;
  logic        imem_rdata_vld = 1'b0;
  logic [31:0] BrPC = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, inst_vld;
  logic [31:0] imem_addr, inst_out, PC_out;
  int checks = 0;
  int errors = 0;
  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .Branch(Branch), .BrPC(BrPC), .stall(stall),
    .imem_rdy(imem_rdy), .imem_rdata_vld(imem_rdata_vld), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .inst_vld(inst_vld),
    .inst_out(inst_out), .PC_out(PC_out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] dat(input logic [31:0] p);
    return p ^ 32'hA5A5_5A5A;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drv(input int br, input logic [31:0] bpc, input int st, input int rdy, input int vld, input logic [31:0] d);
    Branch = 1'(br);
    BrPC = bpc;
    stall = 1'(st);
    imem_rdy = 1'(rdy);
    imem_rdata_vld = 1'(vld);
    imem_rdata = (vld != 0) ? dat(d) : 32'h0;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_vld", 32'(inst_vld), 0);
    chk("rst_inst", inst_out, 0);
    chk("rst_pc", PC_out, 0);
    chk("rst_addr", imem_addr, 0);
    rst = 1'b0;
    drv(0, 0, 0, 1, 0, 0);
    chk("c0_req", 32'(imem_req), 1); chk("c0_addr", imem_addr, 0); chk("c0_vld", 32'(inst_vld), 0);
    tick;
    drv(0, 0, 0, 1, 1, 0);
    chk("c1_addr", imem_addr, 4); chk("c1_vld", 32'(inst_vld), 0);
    tick;
    drv(0, 0, 0, 1, 1, 4);
    chk("c2_vld", 32'(inst_vld), 1); chk("c2_pc", PC_out, 0); chk("c2_inst", inst_out, dat(0)); chk("c2_req", 32'(imem_req), 0);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    chk("c3_vld", 32'(inst_vld), 1); chk("c3_pc", PC_out, 4); chk("c3_inst", inst_out, dat(4)); chk("c3_addr", imem_addr, 8);
    tick;
    drv(0, 0, 0, 1, 1, 8);
    chk("c4_vld", 32'(inst_vld), 0); chk("c4_addr", imem_addr, 12);
    tick;
    drv(0, 0, 1, 1, 1, 12);
    chk("c5_pc", PC_out, 8); chk("c5_req", 32'(imem_req), 0);
    tick;
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 1, 1, 0, 0);
      chk("stall_req", 32'(imem_req), 0); chk("stall_pc", PC_out, 8); chk("stall_vld", 32'(inst_vld), 1);
      tick;
    end
    drv(0, 0, 0, 1, 0, 0);
    chk("drain0_pc", PC_out, 8); chk("drain0_req", 32'(imem_req), 0);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk("drain1_pc", PC_out, 12); chk("drain1_inst", inst_out, dat(12)); chk("drain1_req", 32'(imem_req), 1); chk("drain1_addr", imem_addr, 16);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk("hold_vld", 32'(inst_vld), 0); chk("hold_req", 32'(imem_req), 1); chk("hold_addr", imem_addr, 16);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    chk("acc16_addr", imem_addr, 16);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    chk("acc20_addr", imem_addr, 20);
    tick;
    drv(1, 32'h100, 0, 1, 0, 0);
    chk("br1_req", 32'(imem_req), 0);
    tick;
    drv(0, 0, 0, 1, 1, 16);
    chk("drop0_req", 32'(imem_req), 0); chk("drop0_vld", 32'(inst_vld), 0);
    tick;
    drv(0, 0, 0, 1, 1, 20);
    chk("drop1_req", 32'(imem_req), 1); chk("drop1_addr", imem_addr, 32'h100); chk("drop1_vld", 32'(inst_vld), 0);
    tick;
    drv(0, 0, 0, 1, 1, 32'h100);
    chk("tgt_vld", 32'(inst_vld), 0); chk("tgt_addr", imem_addr, 32'h104);
    tick;
    drv(1, 32'h103, 0, 1, 1, 32'h104);
    chk("br2_vld", 32'(inst_vld), 1); chk("br2_pc", PC_out, 32'h100); chk("br2_inst", inst_out, dat(32'h100)); chk("br2_req", 32'(imem_req), 0);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    chk("flush_vld", 32'(inst_vld), 0); chk("align_req", 32'(imem_req), 1); chk("align_addr", imem_addr, 32'h100);
    tick;
    drv(0, 0, 0, 1, 1, 32'h100);
    chk("post_addr", imem_addr, 32'h104);
    tick;
    drv(0, 0, 0, 1, 1, 32'h104);
    chk("post_pc0", PC_out, 32'h100);
    tick;
    drv(1, 32'hFFFF_FFFC, 0, 1, 0, 0);
    chk("post_pc1", PC_out, 32'h104);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC); chk("top_vld", 32'(inst_vld), 0);
    tick;
    drv(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 0);
    tick;
    drv(0, 0, 1, 1, 1, 0);
    chk("wrap_pc", PC_out, 32'hFFFF_FFFC); chk("wrap_inst", inst_out, dat(32'hFFFF_FFFC));
    tick;
    drv(0, 0, 1, 1, 0, 0);
    chk("full_vld", 32'(inst_vld), 1); chk("full_req", 32'(imem_req), 0); chk("full_pc", PC_out, 32'hFFFF_FFFC);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req), 0);
    chk("arst_vld", 32'(inst_vld), 0);
    chk("arst_inst", inst_out, 0);
    chk("arst_pc", PC_out, 0);
    chk("arst_addr", imem_addr, 0);
    tick;
    tick;
    rst = 1'b0;
    drv(0, 0, 0, 1, 0, 0);
    chk("rel_req", 32'(imem_req), 1); chk("rel_addr", imem_addr, 0); chk("rel_vld", 32'(inst_vld), 0);
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
